npu_cmd_queue: RTL

- Parametrised successor to the single-shot MMIO front-end of the NPU control path.
- Host writes staging registers (CMD, ADDR, ARG, a multi-beat MMVR), then rings a doorbell; each doorbell pushes one complete command into a DEPTH-entry FIFO.
- A valid/ready dispatcher hands FIFO commands to the control unit one at a time and tracks completions.
- The host can therefore queue up to DEPTH commands without polling between them.

---
 rtl/npu_cmd_queue_if.sv | 42 ++++
 rtl/npu_cmd_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/npu_cmd_queue_if.sv
// Host MMIO and command-dispatch signal bundle for the NPU command queue.
//
// Handshake rules for the command channel: the queue raises cmd_valid while a
// command sits at the FIFO head and nothing is in flight. A command transfers
// on every rising clock edge where cmd_valid and cmd_ready are both high.
// cmd_op/cmd_addr/cmd_arg/cmd_mmvr stay stable while cmd_valid is high and
// cmd_ready is low. cmd_valid never depends on cmd_ready. cmd_done is a
// one-cycle pulse from the control unit marking completion of the transferred
// command.
interface npu_cmd_queue_if #(
   parameter int HOST_DW = 32,
   parameter int MMIO_AW = 4,
   parameter int ADDR_W  = 16,
   parameter int ARG_W   = 32,
   parameter int BUF_W   = 128
);
   logic [MMIO_AW-1:0] host_addr;
   logic [HOST_DW-1:0] host_wr_data;
   logic               host_wr_en;
   logic               host_rd_en;
   logic [HOST_DW-1:0] host_rd_data;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [HOST_DW-1:0] cmd_op;
   logic [ADDR_W-1:0]  cmd_addr;
   logic [ARG_W-1:0]   cmd_arg;
   logic [BUF_W-1:0]   cmd_mmvr;
   logic               cmd_done;
   logic               irq;

   // Queue side.
   modport slave (
      input  host_addr, host_wr_data, host_wr_en, host_rd_en, cmd_ready, cmd_done,
      output host_rd_data, cmd_valid, cmd_op, cmd_addr, cmd_arg, cmd_mmvr, irq
   );

   // Host / control-unit side.
   modport master (
      output host_addr, host_wr_data, host_wr_en, host_rd_en, cmd_ready, cmd_done,
      input  host_rd_data, cmd_valid, cmd_op, cmd_addr, cmd_arg, cmd_mmvr, irq
   );
endinterface

// File: rtl/npu_cmd_queue.sv
// NPU command queue: MMIO staging registers, doorbell-driven command FIFO and
// a one-at-a-time valid/ready dispatcher with completion counting and IRQ.
module npu_cmd_queue #(
   parameter int HOST_DW = 32,
   parameter int MMIO_AW = 4,
   parameter int ADDR_W  = 16,
   parameter int ARG_W   = 32,
   parameter int BUF_W   = 128,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   npu_cmd_queue_if.slave   bus,
   output logic             dbg_state
);

   localparam int BEATS    = BUF_W / HOST_DW;
   localparam int PTR_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW       = $clog2(DEPTH);
   localparam int CNT_BITS = AW + 1;

   localparam logic [PTR_W-1:0]    LAST_BEAT = PTR_W'(BEATS - 1);
   localparam logic [CNT_BITS-1:0] FULL_CNT  = CNT_BITS'(DEPTH);

   localparam logic [MMIO_AW-1:0] A_CMD      = MMIO_AW'(0);
   localparam logic [MMIO_AW-1:0] A_ADDR     = MMIO_AW'(1);
   localparam logic [MMIO_AW-1:0] A_ARG      = MMIO_AW'(2);
   localparam logic [MMIO_AW-1:0] A_MMVR     = MMIO_AW'(3);
   localparam logic [MMIO_AW-1:0] A_DOORBELL = MMIO_AW'(4);
   localparam logic [MMIO_AW-1:0] A_STATUS   = MMIO_AW'(5);
   localparam logic [MMIO_AW-1:0] A_IRQ_ACK  = MMIO_AW'(6);
   localparam logic [MMIO_AW-1:0] A_DONE_CNT = MMIO_AW'(7);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Staging registers
   logic [HOST_DW-1:0] stg_cmd_q;
   logic [ADDR_W-1:0]  stg_addr_q;
   logic [ARG_W-1:0]   stg_arg_q;
   logic [BUF_W-1:0]   stg_mmvr_q;
   logic [PTR_W-1:0]   beat_ptr_q;

   // FIFO storage and pointers (extra MSB separates full from empty)
   logic [HOST_DW-1:0] fifo_op   [DEPTH];
   logic [ADDR_W-1:0]  fifo_addr [DEPTH];
   logic [ARG_W-1:0]   fifo_arg  [DEPTH];
   logic [BUF_W-1:0]   fifo_mmvr [DEPTH];
   logic [CNT_BITS-1:0] wr_ptr_q, rd_ptr_q, fifo_count;
   logic [AW-1:0]       wr_idx, rd_idx;
   logic                fifo_empty, fifo_full;

   logic [CNT_W-1:0]   done_cnt_q;
   logic               irq_pending_q;
   logic               overflow_q;
   logic [HOST_DW-1:0] rd_data_q, rd_mux, status;

   logic wr_cmd, wr_addr, wr_arg, wr_mmvr, wr_bell, wr_ack;
   logic valid_c, pop, done_evt, busy, push, ovf_set;

   assign wr_cmd  = bus.host_wr_en && (bus.host_addr == A_CMD);
   assign wr_addr = bus.host_wr_en && (bus.host_addr == A_ADDR);
   assign wr_arg  = bus.host_wr_en && (bus.host_addr == A_ARG);
   assign wr_mmvr = bus.host_wr_en && (bus.host_addr == A_MMVR);
   assign wr_bell = bus.host_wr_en && (bus.host_addr == A_DOORBELL);
   assign wr_ack  = bus.host_wr_en && (bus.host_addr == A_IRQ_ACK);

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (fifo_count == FULL_CNT);
   assign wr_idx     = wr_ptr_q[AW-1:0];
   assign rd_idx     = rd_ptr_q[AW-1:0];

   // A doorbell into a full FIFO still lands if the head leaves in the same cycle.
   assign push    = wr_bell && (!fifo_full || pop);
   assign ovf_set = wr_bell && fifo_full && !pop;

   // Dispatcher next-state and handshake decode.
   always_comb begin
      state_d  = state_q;
      valid_c  = 1'b0;
      pop      = 1'b0;
      done_evt = 1'b0;
      busy     = 1'b0;
      case (state_q)
         S_IDLE: begin
            valid_c = !fifo_empty;
            if (valid_c && bus.cmd_ready) begin
               pop     = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (bus.cmd_done) begin
               done_evt = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Dispatcher state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Host staging registers and MMVR beat pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_cmd_q  <= '0;
         stg_addr_q <= '0;
         stg_arg_q  <= '0;
         stg_mmvr_q <= '0;
         beat_ptr_q <= '0;
      end else begin
         if (wr_cmd)  stg_cmd_q  <= bus.host_wr_data;
         if (wr_addr) stg_addr_q <= bus.host_wr_data[ADDR_W-1:0];
         if (wr_arg)  stg_arg_q  <= bus.host_wr_data[ARG_W-1:0];
         if (wr_mmvr) begin
            stg_mmvr_q[int'(beat_ptr_q)*HOST_DW +: HOST_DW] <= bus.host_wr_data;
            beat_ptr_q <= (beat_ptr_q == LAST_BEAT) ? '0 : beat_ptr_q + PTR_W'(1);
         end
         if (wr_bell) beat_ptr_q <= '0;
      end
   end

   // FIFO storage write; contents are masked at the outputs while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_idx]   <= stg_cmd_q;
         fifo_addr[wr_idx] <= stg_addr_q;
         fifo_arg[wr_idx]  <= stg_arg_q;
         fifo_mmvr[wr_idx] <= stg_mmvr_q;
      end
   end

   // FIFO read/write pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + CNT_BITS'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + CNT_BITS'(1);
      end
   end

   // Completion counter, interrupt pending and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt_q    <= '0;
         irq_pending_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         if (done_evt) done_cnt_q <= done_cnt_q + CNT_W'(1);
         if (done_evt)    irq_pending_q <= 1'b1;
         else if (wr_ack) irq_pending_q <= 1'b0;
         if (ovf_set)     overflow_q <= 1'b1;
         else if (wr_ack) overflow_q <= 1'b0;
      end
   end

   // STATUS word and host read mux.
   always_comb begin
      status       = '0;
      status[0]    = busy;
      status[1]    = fifo_full;
      status[2]    = fifo_empty;
      status[3]    = overflow_q;
      status[4]    = irq_pending_q;
      status[15:8] = 8'(fifo_count);
      rd_mux       = '0;
      case (bus.host_addr)
         A_CMD:      rd_mux = stg_cmd_q;
         A_ADDR:     rd_mux = HOST_DW'(stg_addr_q);
         A_ARG:      rd_mux = HOST_DW'(stg_arg_q);
         A_STATUS:   rd_mux = status;
         A_DONE_CNT: rd_mux = HOST_DW'(done_cnt_q);
         default:    rd_mux = '0;
      endcase
   end

   // Registered read data, held between reads.
   always_ff @(posedge clk) begin
      if (rst)                 rd_data_q <= '0;
      else if (bus.host_rd_en) rd_data_q <= rd_mux;
   end

   assign bus.host_rd_data = rd_data_q;
   assign bus.cmd_valid    = valid_c;
   assign bus.cmd_op       = fifo_empty ? '0 : fifo_op[rd_idx];
   assign bus.cmd_addr     = fifo_empty ? '0 : fifo_addr[rd_idx];
   assign bus.cmd_arg      = fifo_empty ? '0 : fifo_arg[rd_idx];
   assign bus.cmd_mmvr     = fifo_empty ? '0 : fifo_mmvr[rd_idx];
   assign bus.irq          = irq_pending_q;
   assign dbg_state        = state_q;

endmodule
